// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issues one command to an external registered ALU cmd_cnt+1 times, feeding each result back as operand a
// Optional result flags (res_zero, res_neg) are built only when ALU_SEQ_FLAGS_EN is defined.
module alu_sequencer #(
   parameter int N = 4,
   parameter int M = 4,
   parameter int C = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [M-2:0] cmd_op,
   input  logic [N-1:0] cmd_a,
   input  logic [N-1:0] cmd_b,
   input  logic [C-1:0] cmd_cnt,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [M-2:0] alu_op,
   input  logic [N-1:0] alu_out,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [N-1:0] res_data,
`ifdef ALU_SEQ_FLAGS_EN
   output logic         res_zero,
   output logic         res_neg,
`endif
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [C-1:0]  rem;
   logic          accept;
   logic          reissue;
   logic          finish;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      reissue    = 1'b0;
      finish     = 1'b0;
      cmd_ready  = 1'b0;
      res_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               accept     = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            state_next = WAIT;
         end
         WAIT: begin
            // rem counts issues still owed after the current one, so 0 means this result is final
            if (rem != '0) begin
               reissue    = 1'b1;
               state_next = ISSUE;
            end else begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a <= '0;
         alu_b <= '0;
         alu_op <= '0;
         rem <= '0;
      end else if (accept) begin
         alu_a <= cmd_a;
         alu_b <= cmd_b;
         alu_op <= cmd_op;
         rem <= cmd_cnt;
      end else if (reissue) begin
         alu_a <= alu_out;
         rem <= rem - C'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_data <= '0;
      end else if (finish) begin
         res_data <= alu_out;
      end
   end

`ifdef ALU_SEQ_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         res_zero <= 1'b0;
         res_neg <= 1'b0;
      end else if (finish) begin
         res_zero <= (alu_out == '0);
         res_neg <= alu_out[N-1];
      end
   end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed bench for alu_sequencer with a registered reference ALU; flag checks follow ALU_SEQ_FLAGS_EN
module tb_alu_sequencer;
   localparam int N = 4;
   localparam int M = 4;
   localparam int C = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [M-2:0] cmd_op;
   logic [N-1:0] cmd_a;
   logic [N-1:0] cmd_b;
   logic [C-1:0] cmd_cnt;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [M-2:0] alu_op;
   logic [N-1:0] alu_out;
   logic         res_valid;
   logic         res_ready;
   logic [N-1:0] res_data;
   logic         busy;
`ifdef ALU_SEQ_FLAGS_EN
   logic         res_zero;
   logic         res_neg;
`endif

   int checks = 0;
   int errors = 0;
   logic [N-1:0] issue_a [0:15];
   int n_issue;
   int lat;

   always #5 clk = ~clk;

   alu_sequencer #(.N(N), .M(M), .C(C)) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_a(cmd_a),
      .cmd_b(cmd_b),
      .cmd_cnt(cmd_cnt),
      .alu_a(alu_a),
      .alu_b(alu_b),
      .alu_op(alu_op),
      .alu_out(alu_out),
      .res_valid(res_valid),
      .res_ready(res_ready),
      .res_data(res_data),
`ifdef ALU_SEQ_FLAGS_EN
      .res_zero(res_zero),
      .res_neg(res_neg),
`endif
      .busy(busy)
   );

   function automatic logic [N-1:0] alu_f(input logic [N-1:0] a, input logic [N-1:0] b, input logic [M-2:0] op);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b011:  return a | b;
         3'b100:  return {a[N-2:0], 1'b0};
         3'b101:  return {1'b0, a[N-1:1]};
         3'b110:  return a ^ b;
         default: return {a[N-2:0], a[N-1]};
      endcase
   endfunction

   always_ff @(posedge clk) alu_out <= alu_f(alu_a, alu_b, alu_op);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Starts at a negedge in IDLE, ends at the first negedge with res_valid high.
   task automatic run_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] cnt, output int latency);
      check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_a = a;
      cmd_b = b;
      cmd_cnt = cnt;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      check("alu_op_issue", 32'(alu_op), 32'(op));
      issue_a[0] = alu_a;
      n_issue = 1;
      latency = 0;
      while (latency < 40) begin
         @(posedge clk);
         latency++;
         @(negedge clk);
         if (res_valid) break;
         if (latency % 2 == 0 && n_issue < 16) begin
            issue_a[n_issue] = alu_a;
            n_issue++;
         end
      end
      if (!res_valid) check("res_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic consume();
      check("cmd_ready_done", 32'(cmd_ready), 32'd0);
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      check("res_valid_after_consume", 32'(res_valid), 32'd0);
      check("busy_after_consume", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      cmd_op = '0;
      cmd_a = '0;
      cmd_b = '0;
      cmd_cnt = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_b", 32'(alu_b), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check("rst_res_data", 32'(res_data), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
      check("rst_res_zero", 32'(res_zero), 32'd0);
      check("rst_res_neg", 32'(res_neg), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);

      run_cmd(3'b000, 4'd3, 4'd4, 3'd0, lat);
      check("add_lat", 32'(lat), 32'd2);
      check("add_data", 32'(res_data), 32'd7);
      consume();

      run_cmd(3'b001, 4'd2, 4'd5, 3'd0, lat);
      check("sub_wrap_lat", 32'(lat), 32'd2);
      check("sub_wrap_data", 32'(res_data), 32'd13);
`ifdef ALU_SEQ_FLAGS_EN
      check("sub_wrap_neg", 32'(res_neg), 32'd1);
      check("sub_wrap_zero", 32'(res_zero), 32'd0);
`endif
      consume();

      run_cmd(3'b001, 4'd5, 4'd5, 3'd0, lat);
      check("sub_zero_data", 32'(res_data), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
      check("sub_zero_zero", 32'(res_zero), 32'd1);
      check("sub_zero_neg", 32'(res_neg), 32'd0);
`endif
      consume();

      run_cmd(3'b100, 4'b0001, 4'd0, 3'd2, lat);
      check("shl_lat", 32'(lat), 32'd6);
      check("shl_data", 32'(res_data), 32'b1000);
      check("shl_issues", 32'(n_issue), 32'd3);
      check("shl_issue0", 32'(issue_a[0]), 32'b0001);
      check("shl_issue1", 32'(issue_a[1]), 32'b0010);
      check("shl_issue2", 32'(issue_a[2]), 32'b0100);
      consume();

      run_cmd(3'b111, 4'b0001, 4'd0, 3'd3, lat);
      check("rot_lat", 32'(lat), 32'd8);
      check("rot_data", 32'(res_data), 32'b0001);
      check("rot_issue3", 32'(issue_a[3]), 32'b1000);
      cmd_valid = 1'b1;
      cmd_op = 3'b000;
      cmd_a = 4'd9;
      cmd_b = 4'd9;
      cmd_cnt = 3'd0;
      for (int i = 0; i < 5; i++) begin
         check("hold_res_valid", 32'(res_valid), 32'd1);
         check("hold_res_data", 32'(res_data), 32'b0001);
         check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("hold_alu_a", 32'(alu_a), 32'b1000);
      consume();

      run_cmd(3'b000, 4'd0, 4'd1, 3'd7, lat);
      check("maxcnt_lat", 32'(lat), 32'd16);
      check("maxcnt_data", 32'(res_data), 32'd8);
      consume();

      run_cmd(3'b010, 4'd12, 4'd10, 3'd0, lat);
      check("and_data", 32'(res_data), 32'd8);
      consume();

      cmd_valid = 1'b1;
      cmd_op = 3'b100;
      cmd_a = 4'b0001;
      cmd_b = 4'd0;
      cmd_cnt = 3'd2;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("mid_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      res_ready = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      res_ready = 1'b0;
      @(negedge clk);
      check("mid_res_valid", 32'(res_valid), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_cmd_ready", 32'(cmd_ready), 32'd1);
      begin
         logic saw_valid;
         saw_valid = 1'b0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_valid) saw_valid = 1'b1;
         end
         check("mid_no_result", 32'(saw_valid), 32'd0);
      end

      run_cmd(3'b000, 4'd1, 4'd1, 3'd0, lat);
      check("post_rst_lat", 32'(lat), 32'd2);
      check("post_rst_data", 32'(res_data), 32'd2);
      consume();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning the operand and result width in bits.
REQ-002 The module SHALL have parameter M, default 4, meaning the opcode field width plus one, so opcodes are M-1 bits wide.
REQ-003 The module SHALL have parameter C, default 3, meaning the repeat-count width in bits.
REQ-004 Port clk, input, 1 bit: the single clock; every register SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port cmd_valid, input, 1 bit: a command is offered.
REQ-007 Port cmd_ready, output, 1 bit: the sequencer can accept a command.
REQ-008 Port cmd_op, input, M-1 bits: the arithmetic opcode.
REQ-009 Port cmd_a, input, N bits: operand a.
REQ-010 Port cmd_b, input, N bits: operand b.
REQ-011 Port cmd_cnt, input, C bits: the number of issues minus one.
REQ-012 Port alu_a, output, N bits: operand a driven to the arithmetic unit.
REQ-013 Port alu_b, output, N bits: operand b driven to the arithmetic unit.
REQ-014 Port alu_op, output, M-1 bits: the opcode driven to the arithmetic unit.
REQ-015 Port alu_out, input, N bits: the registered result from the arithmetic unit, valid one clk after the unit samples its inputs.
REQ-016 Port res_valid, output, 1 bit: res_data holds a final result.
REQ-017 Port res_ready, input, 1 bit: the consumer accepts the result.
REQ-018 Port res_data, output, N bits: the final result.
REQ-019 Port busy, output, 1 bit: the sequencer is not in the IDLE state.

Function
REQ-020 The FSM SHALL have four states, IDLE, ISSUE, WAIT and DONE, encoded in 2 bits.
REQ-021 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a clk edge where cmd_valid and cmd_ready are both 1.
REQ-022 On acceptance, the sequencer SHALL register cmd_a into alu_a, cmd_b into alu_b, cmd_op into alu_op and cmd_cnt into the remaining-count register rem, then enter ISSUE.
REQ-023 ISSUE SHALL last one cycle, during which the arithmetic unit samples alu_a, alu_b and alu_op; the next state SHALL be WAIT.
REQ-024 WAIT SHALL last one cycle; at its end the sequencer SHALL sample alu_out.
REQ-025 From WAIT with rem not equal to 0, the sequencer SHALL load alu_out into alu_a, decrement rem by 1, leave alu_b and alu_op unchanged, and enter ISSUE.
REQ-026 From WAIT with rem equal to 0, the sequencer SHALL load alu_out into res_data and enter DONE.
REQ-027 In DONE, res_valid SHALL be 1; on an edge with res_ready equal to 1, the sequencer SHALL enter IDLE and res_valid SHALL fall.
REQ-028 While res_ready is 0, res_valid and res_data SHALL remain stable.
REQ-029 Latency SHALL be exactly 2*(cmd_cnt+1) cycles from command acceptance to the first cycle of res_valid.
REQ-030 No new command SHALL be accepted in the same cycle that a result is consumed; the earliest next acceptance is one cycle after returning to IDLE.
REQ-031 cmd_cnt equal to 2^C-1 SHALL produce 2^C issues with no wrap of rem.
REQ-032 All arithmetic SHALL wrap modulo 2^N, inherited from the arithmetic unit.
REQ-033 Opcodes outside the defined set SHALL be passed through unchanged; the result is whatever the arithmetic unit returns.

Reset
REQ-034 While rst is 1 at a clk edge, the state SHALL be IDLE, and busy, res_valid and rem SHALL be 0.
REQ-035 While rst is 1 at a clk edge, alu_a, alu_b, alu_op and res_data SHALL be 0, and cmd_ready SHALL be 1 from the first cycle after reset.
REQ-036 A reset asserted mid-operation SHALL abandon the operation without emitting a result.
REQ-037 rst SHALL take priority over a simultaneous command or result handshake.

Configuration
REQ-038 When macro ALU_SEQ_FLAGS_EN is defined, the module SHALL add output ports res_zero and res_neg, each 1 bit.
REQ-039 With ALU_SEQ_FLAGS_EN defined, res_zero SHALL be 1 when the value loaded into res_data is 0, registered alongside res_data.
REQ-040 With ALU_SEQ_FLAGS_EN defined, res_neg SHALL equal the MSB of the value loaded into res_data, registered alongside res_data.
REQ-041 With ALU_SEQ_FLAGS_EN defined, res_zero and res_neg SHALL reset to 0 and SHALL hold with res_data while res_valid is 1.
REQ-042 When ALU_SEQ_FLAGS_EN is undefined, the ports res_zero and res_neg and their registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-043 The bench SHALL cover: op=000, a=3, b=4, cnt=0 -> res_data=7, with res_valid 2 cycles after acceptance.
REQ-044 The bench SHALL cover: op=001, a=2, b=5, cnt=0 -> res_data=13 (wrap), and with flags enabled res_neg=1 and res_zero=0.
REQ-045 The bench SHALL cover: op=100, a=0001, cnt=2 -> res_data=1000 after 6 cycles, with alu_a observed as 0001, 0010, 0100 on successive issues.
REQ-046 The bench SHALL cover: op=111, a=0001, cnt=3 -> res_data=0001 after 8 cycles; res_ready held 0 for 5 cycles -> res_valid and res_data stable and cmd_ready=0 throughout.
REQ-047 The bench SHALL cover: rst pulsed in the second WAIT of a cnt=2 command -> no res_valid, busy=0, cmd_ready=1 the next cycle, and a following add 1+1 returns 2.
